// File: rtl/cpu_clock_controller.sv
// CPU clock sequencer: emits a one-cycle tick enable in the mclk domain (free-run, single-step, halt).
// Optional macro CLKCTL_BURST_EN adds burst_len_i for multi-tick step bursts.
module cpu_clock_controller #(
    parameter int DIV_WIDTH       = 32,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 run_sw_i,
    input  logic                 step_btn_i,
    input  logic                 halt_req_i,
    input  logic                 clr_halt_i,
    input  logic [DIV_WIDTH-1:0] div_value_i,
`ifdef CLKCTL_BURST_EN
    input  logic [7:0]           burst_len_i,
`endif
    output logic                 tick_o,
    output logic [1:0]           state_o,
    output logic                 halted_o,
    output logic [CNT_WIDTH-1:0] tick_count_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        STEP   = 2'b10,
        HALTED = 2'b11
    } state_t;

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Bit 0 carries run_sw, bit 1 carries step_btn through the conditioning path.
    logic [1:0]      raw_s;
    logic [1:0]      sync1_q, sync2_q, deb_q;
    logic [DB_W-1:0] dbc_q [2];
    logic            step_prev_q;
    logic            run_deb_s, step_rise_s, terminal_s;
    logic [DIV_WIDTH-1:0] div_eff_s;

    state_t               state_q, state_d;
    logic                 tick_q, tick_d;
    logic                 halted_q;
    logic [CNT_WIDTH-1:0] tick_count_q;
    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic [DIV_WIDTH-1:0] div_lat_q, div_lat_d;
`ifdef CLKCTL_BURST_EN
    logic [7:0] burst_rem_q, burst_rem_d;
    logic [7:0] burst_eff_s;
    assign burst_eff_s = (burst_len_i == 8'd0) ? 8'd1 : burst_len_i;
`endif

    assign raw_s       = {step_btn_i, run_sw_i};
    assign run_deb_s   = deb_q[0];
    assign step_rise_s = deb_q[1] & ~step_prev_q;
    assign div_eff_s   = (div_value_i == {DIV_WIDTH{1'b0}}) ? DIV_WIDTH'(1) : div_value_i;
    assign terminal_s  = (div_cnt_q == (div_lat_q - DIV_WIDTH'(1)));

    // Two-flop synchronizers and stable-level debouncers for both board inputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q     <= 2'b00;
            sync2_q     <= 2'b00;
            deb_q       <= 2'b00;
            step_prev_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                dbc_q[i] <= '0;
            end
        end else begin
            sync1_q     <= raw_s;
            sync2_q     <= sync1_q;
            step_prev_q <= deb_q[1];
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    dbc_q[i] <= '0;
                end else if (dbc_q[i] == DB_LAST) begin
                    deb_q[i] <= ~deb_q[i];
                    dbc_q[i] <= '0;
                end else begin
                    dbc_q[i] <= dbc_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Next-state, divider and tick decision; halt outranks mode change, which outranks ticking.
    always_comb begin
        state_d   = state_q;
        tick_d    = 1'b0;
        div_cnt_d = div_cnt_q;
        div_lat_d = div_lat_q;
`ifdef CLKCTL_BURST_EN
        burst_rem_d = burst_rem_q;
`endif
        case (state_q)
            IDLE: begin
                if (halt_req_i) begin
                    state_d = HALTED;
                end else if (run_deb_s) begin
                    state_d   = RUN;
                    div_cnt_d = '0;
                    div_lat_d = div_eff_s;
                end else if (step_rise_s) begin
                    state_d   = STEP;
                    tick_d    = 1'b1;
                    div_cnt_d = '0;
                    div_lat_d = div_eff_s;
`ifdef CLKCTL_BURST_EN
                    burst_rem_d = burst_eff_s - 8'd1;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (halt_req_i) begin
                    state_d   = HALTED;
                    div_cnt_d = '0;
                end else if (!run_deb_s) begin
                    state_d   = IDLE;
                    div_cnt_d = '0;
                end else if (terminal_s) begin
                    tick_d    = 1'b1;
                    div_cnt_d = '0;
                    div_lat_d = div_eff_s;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
                end
            end
            STEP: begin
`ifdef CLKCTL_BURST_EN
                if (halt_req_i) begin
                    state_d   = HALTED;
                    div_cnt_d = '0;
                end else if (burst_rem_q == 8'd0) begin
                    state_d   = IDLE;
                    div_cnt_d = '0;
                end else if (terminal_s) begin
                    tick_d      = 1'b1;
                    div_cnt_d   = '0;
                    burst_rem_d = burst_rem_q - 8'd1;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
                end
`else
                if (halt_req_i) begin
                    state_d = HALTED;
                end else begin
                    state_d = IDLE;
                end
`endif
            end
            HALTED: begin
                if (clr_halt_i && !halt_req_i) begin
                    state_d   = run_deb_s ? RUN : IDLE;
                    div_cnt_d = '0;
                    div_lat_d = div_eff_s;
                end else begin
                    state_d = HALTED;
                end
            end
            default: begin
                state_d   = IDLE;
                div_cnt_d = '0;
            end
        endcase
    end

    // State, divider and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            tick_q       <= 1'b0;
            halted_q     <= 1'b0;
            tick_count_q <= '0;
            div_cnt_q    <= '0;
            div_lat_q    <= DIV_WIDTH'(1);
`ifdef CLKCTL_BURST_EN
            burst_rem_q  <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            halted_q     <= (state_d == HALTED);
            tick_count_q <= tick_count_q + CNT_WIDTH'(tick_d);
            div_cnt_q    <= div_cnt_d;
            div_lat_q    <= div_lat_d;
`ifdef CLKCTL_BURST_EN
            burst_rem_q  <= burst_rem_d;
`endif
        end
    end

    assign tick_o       = tick_q;
    assign state_o      = state_q;
    assign halted_o     = halted_q;
    assign tick_count_o = tick_count_q;

endmodule

// File: doc/cpu_clock_controller.md
Name: cpu_clock_controller

Overview:
- Sequences the 8-bit CPU's clock. It produces a single-cycle clock-enable pulse, `tick`, in the mclk domain instead of a derived clock.
- Supports free-run at a programmable rate, manual single-step from a debounced button, and halt on CPU request with explicit release.
- Sits between the board inputs (mclk, buttons, switches) and every CPU register's clock-enable.

Parameters:
- DIV_WIDTH, 32, width of the rate divisor and divider counter.
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles before a button or switch level is accepted (10 ms at 100 MHz).
- CNT_WIDTH, 16, width of the tick counter.

Ports:
- clk  in  1  system clock, 100 MHz mclk.
- rst  in  1  synchronous, active-high reset.
- run_sw  in  1  raw switch: 1 = free-run, 0 = manual step.
- step_btn  in  1  raw step pushbutton, active high.
- halt_req  in  1  CPU HLT decode, level.
- clr_halt  in  1  pulse that releases HALTED.
- div_value  in  DIV_WIDTH  mclk cycles per tick in RUN; 0 is treated as 1.
- tick  out  1  one-cycle CPU clock enable.
- state  out  2  IDLE=00, RUN=01, STEP=10, HALTED=11.
- halted  out  1  high while in HALTED.
- tick_count  out  CNT_WIDTH  total ticks issued; wraps.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - state=IDLE, tick=0, halted=0, tick_count=0.
  - Divider counter=0, debounced levels=0, synchronizers=0.
- Input conditioning:
  - run_sw and step_btn each pass through a 2-FF synchronizer, then a debouncer.
  - The debouncer's counter increments while the synchronized level differs from the debounced level and clears when they match.
  - The debounced level flips when the counter reaches DEBOUNCE_CYCLES-1.
  - step_rise = debounced step high this cycle, low the previous cycle.
- FSM (registered; tick is registered, high exactly one cycle per issue):
  - IDLE:
    - halt_req → HALTED.
    - else run_deb=1 → RUN, with divider cleared and div_value latched.
    - else step_rise → STEP.
  - STEP: tick=1 for this one cycle, tick_count+1; next state IDLE.
  - RUN:
    - The counter counts 0..div_lat-1.
    - At div_lat-1: tick=1, counter→0, div_value re-latched.
    - halt_req → HALTED.
    - run_deb=0 → IDLE with counter cleared; no partial tick is issued.
  - HALTED: no ticks. clr_halt → RUN if run_deb=1, else IDLE. The divider is cleared on exit.
- Priority: halt_req > run_sw change > step_rise/divider terminal count.
  - halt_req in the same cycle as a terminal count suppresses that tick.
  - halt_req during STEP does not cancel that step's tick; HALTED is entered on the next cycle.
- clr_halt outside HALTED is ignored. clr_halt and halt_req both high in HALTED: remain HALTED.
- step_rise outside IDLE is discarded; it is not queued.
- div_value changes take effect only at the next wrap or at RUN entry.
- Latency: step_btn raw stable high → tick high after DEBOUNCE_CYCLES+3 clk cycles.
- RUN period: exactly max(div_value,1) cycles between ticks; first tick div_lat cycles after entering RUN.
- Mid-operation rst forces all of the above to their reset values on the next edge, including an in-progress debounce.

Optional Feature:
- Macro: CLKCTL_BURST_EN.
- With the macro defined:
  - Adds input burst_len [7:0]; 0 is treated as 1.
  - step_rise in IDLE enters STEP, which issues burst_len ticks spaced div_lat cycles apart (first tick immediately), then returns to IDLE.
  - halt_req aborts the remaining burst after the current tick.
  - run_sw has no effect until the burst completes.
- Without the macro: exactly one tick per step_rise; no burst_len port.

Test Plan:
- All tests use DEBOUNCE_CYCLES=4.
- Reset: rst=1 for 2 cycles with all inputs high → state=00, tick=0, tick_count=0 in the cycle after rst falls.
- Single step: run_sw=0, step_btn high for 20 cycles → exactly one tick, 7 cycles after the rise; tick_count=1; state returns to 00. Bouncing pulse 0-1-0 of 2 cycles → no tick.
- Free-run: run_sw=1, div_value=5 → ticks every 5 cycles; 10 ticks seen in 50 cycles. div_value=0 → tick every cycle. Change div_value to 3 mid-period → current period stays 5, next 3.
- Halt: RUN with div_value=4, assert halt_req on a terminal-count cycle → that tick suppressed, state=11, halted=1, no ticks for 100 cycles. clr_halt → RUN; first tick 4 cycles later.
- Mode switch: RUN with counter mid-count, run_sw→0 → state=00 after debounce, no further ticks; step press in RUN → ignored, tick_count unchanged.
- Wrap: preload 0xFFFF ticks (CNT_WIDTH=16) → next tick gives tick_count=0x0000. With CLKCTL_BURST_EN, burst_len=3, div_value=2 → ticks at t, t+2, t+4, then IDLE.
